// File: rtl/i2s_pkg.sv
// Shared constants, FSM state encoding and sample packing helper for the i2s sample FIFO.
package i2s_pkg;

  localparam int SAMPLE_W = 32;
  localparam int CHAN_W   = 16;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [CHAN_W-1:0] left;
    logic [CHAN_W-1:0] right;
  } stereo_t;

  function automatic logic [SAMPLE_W-1:0] pack_lr(input logic [CHAN_W-1:0] left,
                                                 input logic [CHAN_W-1:0] right);
    return {left, right};
  endfunction

endpackage

// File: rtl/i2s_fifo_ram.sv
// Sample storage for the i2s FIFO: registered write port, asynchronous read port.
module i2s_fifo_ram #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clkin,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clkin) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/i2s_sample_fifo.sv
// Stereo sample FIFO feeding the i2s transmitter, with prefill/underflow sequencing.
// Optional statistics outputs are enabled by defining I2S_SAMPLE_FIFO_STATS_EN.
//
// state   | meaning
// ST_FILL | output muted, waiting for level >= PREFILL
// ST_RUN  | each i2s_ready pulse pops the next sample onto sound
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = SAMPLE_W,
  parameter int PREFILL    = 4
) (
  input  logic                  clkin,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      sound,
  input  logic                  i2s_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  running,
  output logic                  underflow
`ifdef I2S_SAMPLE_FIFO_STATS_EN
  ,
  output logic [15:0]           underflow_cnt,
  output logic [DEPTH_LOG2:0]   peak_level
`endif
);

  localparam int                  DEPTH      = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LV   = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] PREFILL_LV = PREFILL[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LVL_ONE    = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  logic [0:0]            state;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [WIDTH-1:0]      rd_data;
  logic                  wr_en;
  logic                  pop;
  logic                  under_evt;

  assign full      = (level == DEPTH_LV);
  assign empty     = (level == '0);
  assign in_ready  = !full;
  assign running   = (state == ST_RUN);
  assign wr_en     = in_valid && in_ready;
  assign pop       = running && i2s_ready && !empty;
  assign under_evt = running && i2s_ready && empty;

  i2s_fifo_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (WIDTH)
  ) u_ram (
    .clkin  (clkin),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr),
    .wr_data(in_data),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state     <= ST_FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      sound     <= '0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;

      if (wr_en && !pop)      level <= level + LVL_ONE;
      else if (pop && !wr_en) level <= level - LVL_ONE;

      // Any pulse that does not pop (FILL or underflow) mutes the output.
      if (i2s_ready) sound <= pop ? rd_data : '0;

      underflow <= under_evt;

      if (state == ST_FILL) begin
        if (level >= PREFILL_LV) state <= ST_RUN;
      end else if (under_evt) begin
        state <= ST_FILL;
      end
    end
  end

`ifdef I2S_SAMPLE_FIFO_STATS_EN
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      underflow_cnt <= '0;
      peak_level    <= '0;
    end else begin
      if (under_evt && (underflow_cnt != 16'hFFFF)) underflow_cnt <= underflow_cnt + 16'd1;
      if (level > peak_level) peak_level <= level;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Randomized self-checking bench for i2s_sample_fifo against a queue-based sample model.
module tb_i2s_sample_fifo;

  localparam int DEPTH   = 16;
  localparam int PREFILL = 4;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sound;
  logic        i2s_ready;
  logic [4:0]  level;
  logic        empty;
  logic        full;
  logic        running;
  logic        underflow;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q[$];
  logic [31:0] m_sound;
  bit          m_running;
  bit          m_under;
  bit          cmp_en;

  i2s_sample_fifo dut (
    .clkin    (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sound    (sound),
    .i2s_ready(i2s_ready),
    .level    (level),
    .empty    (empty),
    .full     (full),
    .running  (running),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sound   = '0;
    m_running = 1'b0;
    m_under   = 1'b0;
  endtask

  // Model: a plain queue of samples; a pulse in RUN either takes the head or mutes and drops to FILL.
  task automatic model_step();
    int  sz;
    bit  do_wr;
    bit  under;
    sz    = q.size();
    do_wr = in_valid && (sz < DEPTH);
    under = 1'b0;
    if (i2s_ready) begin
      if (m_running && sz > 0) m_sound = q.pop_front();
      else begin
        m_sound = '0;
        under   = m_running;
      end
    end
    m_under = under;
    if (!m_running) m_running = (sz >= PREFILL);
    else if (under) m_running = 1'b0;
    if (do_wr) q.push_back(in_data);
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_sound",     sound,     m_sound);
      chk("cyc_level",     32'(level), 32'(q.size()));
      chk("cyc_empty",     32'(empty), 32'(q.size() == 0));
      chk("cyc_full",      32'(full),  32'(q.size() == DEPTH));
      chk("cyc_in_ready",  32'(in_ready), 32'(q.size() != DEPTH));
      chk("cyc_running",   32'(running),  32'(m_running));
      chk("cyc_underflow", 32'(underflow), 32'(m_under));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse();
    i2s_ready = 1'b1;
    tick();
    i2s_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] pre_words [4];
    int pv, pr;
    pre_words[0] = 32'h0001FFFE;
    pre_words[1] = 32'h0002FFFD;
    pre_words[2] = 32'h0003FFFC;
    pre_words[3] = 32'h0004FFFB;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; i2s_ready = 1'b0; cmp_en = 1'b0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    cmp_en = 1'b1;

    chk("rst_sound", sound, 32'h0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_running", 32'(running), 32'd0);
    pulse();
    chk("fill_pulse_sound", sound, 32'h0);
    chk("fill_pulse_underflow", 32'(underflow), 32'd0);

    for (int i = 0; i < 4; i++) push(pre_words[i]);
    chk("prefill_level4", 32'(level), 32'd4);
    chk("prefill_not_yet_running", 32'(running), 32'd0);
    tick();
    chk("prefill_running", 32'(running), 32'd1);
    for (int i = 0; i < 4; i++) begin
      pulse();
      chk("prefill_out", sound, pre_words[i]);
      tick();
      chk("prefill_hold", sound, pre_words[i]);
    end
    chk("drained_level", 32'(level), 32'd0);

    pulse();
    chk("uf_sound", sound, 32'h0);
    chk("uf_pulse", 32'(underflow), 32'd1);
    chk("uf_running", 32'(running), 32'd0);
    tick();
    chk("uf_pulse_end", 32'(underflow), 32'd0);

    for (int k = 0; k < 4; k++) push(32'h00050000 + 32'(k));
    tick();
    chk("rerun_running", 32'(running), 32'd1);

    in_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      in_data = 32'h00060000 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    chk("full_level", 32'(level), 32'd16);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    pulse();
    chk("full_pop_level", 32'(level), 32'd15);
    chk("full_pop_in_ready", 32'(in_ready), 32'd1);
    chk("full_pop_sound", sound, 32'h00050000);

    for (int k = 0; k < 14; k++) pulse();
    chk("sim_pre_level", 32'(level), 32'd1);
    in_valid = 1'b1; in_data = 32'hAAAA5555; i2s_ready = 1'b1;
    tick();
    in_valid = 1'b0; i2s_ready = 1'b0;
    chk("sim_old_head", sound, 32'h0006000B);
    chk("sim_level", 32'(level), 32'd1);
    pulse();
    chk("sim_new_word", sound, 32'hAAAA5555);

    for (int k = 0; k < 9; k++) push(32'hDEAD0000 + 32'(k));
    chk("mid_pre_level", 32'(level), 32'd9);
    chk("mid_pre_running", 32'(running), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_sound", sound, 32'h0);
    chk("mid_rst_running", 32'(running), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) push(32'h12340000 + 32'(k));
    tick();
    pulse();
    chk("mid_rst_new_data", sound, 32'h12340000);

    for (int ph = 0; ph < 3; ph++) begin
      pv = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
      pr = (ph == 0) ? 25 : (ph == 1) ? 65 : 50;
      for (int c = 0; c < 1000; c++) begin
        in_valid  = ($urandom_range(0, 99) < pv);
        in_data   = $urandom;
        i2s_ready = ($urandom_range(0, 99) < pr);
        tick();
      end
    end
    in_valid = 1'b0; i2s_ready = 1'b0;
    tick();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_sample_fifo.md
Name: i2s_sample_fifo

Overview:
Buffers stereo PCM samples ahead of the i2s transmitter and presents one 32-bit word {left[15:0], right[15:0]} on `sound`. It advances to the next word each time the transmitter pulses `ready`. A prefill state machine mutes output until enough samples are queued, and re-enters prefill after any underflow. It sits between the sample producer (DSP/DDS/test counter) and the i2s block.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).
WIDTH, 32, sample word width ({L,R}).
PREFILL, 4, level required to leave FILL; legal 1..2**DEPTH_LOG2.

Ports:
clkin  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  WIDTH  sample from producer
in_valid  in  1  producer has a sample
in_ready  out  1  FIFO accepts; equals !full (registered state)
sound  out  WIDTH  sample presented to i2s, registered
i2s_ready  in  1  one-cycle pulse from i2s: current sound latched, load next
level  out  DEPTH_LOG2+1  entries stored, 0..2**DEPTH_LOG2
empty  out  1  level==0
full  out  1  level==2**DEPTH_LOG2
running  out  1  FSM in RUN
underflow  out  1  one-cycle pulse on underflow event

Behaviour:
- Reset (async assert, sync release): pointers=0, level=0, sound=0, state=FILL, underflow=0; hence empty=1, full=0, in_ready=1, running=0.
- Storage: circular RAM, DEPTH_LOG2-bit rd/wr pointers wrap naturally; level is a separate counter.
- Write: in_valid && in_ready stores in_data at wr_ptr, wr_ptr+1. Data written in cycle N is poppable from cycle N+1 (no bypass).
- Full: in_ready=0; no write even if a pop occurs the same cycle (in_ready reflects pre-edge state).
- level: +1 on write only, -1 on pop only, unchanged on both.
- FSM FILL: i2s_ready loads sound<=0 with no pop and no underflow. When level>=PREFILL at a clock edge, go to RUN next cycle.
- FSM RUN, i2s_ready with !empty: sound<=mem[rd_ptr], rd_ptr+1, pop. Sound updates one cycle after the pulse and holds until the next pulse.
- FSM RUN, i2s_ready with empty: sound<=0, underflow=1 for one cycle, state->FILL. A same-cycle write is stored, not bypassed.
- No i2s_ready: sound holds its value in every state.
- i2s_ready asserted on consecutive cycles: each cycle is a separate pop. Legal but not expected from i2s.
- Reset mid-operation: all stored samples are discarded; returns to reset values immediately.

Optional Feature:
Macro I2S_SAMPLE_FIFO_STATS_EN.
- With it: extra output underflow_cnt [15:0] increments on each underflow pulse and saturates at 16'hFFFF. Reset to 0. Extra output peak_level [DEPTH_LOG2:0] holds the max level since reset.
- Without it: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package i2s_pkg: SAMPLE_W=32, CHAN_W=16, FSM state encoding (ST_FILL=0, ST_RUN=1), helper for packing {L,R}.
- One sub-module: i2s_fifo_ram (dual-port, registered write, async read, DEPTH_LOG2/WIDTH params).
- FSM, pointers and level stay in the top.

Test Plan:
- Reset: after rst pulse, sound=0, level=0, empty=1, in_ready=1, running=0; pulse i2s_ready -> sound stays 0, underflow=0.
- Prefill: write 0x0001FFFE..0x0004FFFB (4 words, PREFILL=4) -> running=1 the cycle after level=4; pulses output the four words in order, one cycle after each pulse.
- Underflow: in RUN with level=0, pulse i2s_ready -> sound=0, underflow pulse, running=0. Write 4 words -> RUN again; with STATS_EN, underflow_cnt=1.
- Full/backpressure: hold in_valid with no pulses -> after 16 writes full=1, in_ready=0, 17th word not stored. Pulse i2s_ready in RUN -> level 15, in_ready=1 next cycle.
- Simultaneous: level=1 in RUN, write 0xAAAA5555 and pulse in the same cycle -> old head output, level stays 1, next pulse outputs 0xAAAA5555.
- Reset mid-stream: level=9 in RUN, assert rst -> immediate level=0, sound=0, FILL; prior data never output.
